pe_sequencer: RTL
=================

# pe_sequencer

Host-side initiator for one background-removal processing element (PE). It performs these steps in order:
- Buffers a block of `num_pixels` RGB pixels from an input stream.
- Commands the PE to sum the block and derives the expected background colour as the block mean.
- Commands the PE to remove the background against that colour.
- Streams the replaced pixels back out.

It drives the PE's Start_Sum/Start_BgRemoval/Ack handshake and consumes its Qsd/Qbgd done flags.

## Interface
Parameters:
- `LOG2_N`, default 2: log2 of pixels per block. The block size is N = 2**LOG2_N; a power of two is mandatory because the mean is computed by shift.
- `TIMEOUT`, default 1023: maximum number of cycles to wait for a PE done flag.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one block; sampled in IDLE only.
- `threshold`  in  8  copied into `cfg_thr` on start.
- `bg_r`, `bg_g`, `bg_b`  in  8 each  replacement colour; copied into `cfg_bg` on start.
- `pix_valid`, `pix_ready`  in, out  1 each  input stream handshake.
- `pix_r`, `pix_g`, `pix_b`  in  8 each  input pixel.
- `pe_start_sum`, `pe_start_bg`, `pe_ack`  out  1 each  PE command pulses.
- `pe_red_in`, `pe_green_in`, `pe_blue_in`  out  8*N each  buffered pixels; pixel k occupies bits [8k+7:8k].
- `pe_red_exp`, `pe_green_exp`, `pe_blue_exp`, `pe_threshold`  out  8 each  expected colour and latched threshold.
- `pe_bg_r`, `pe_bg_g`, `pe_bg_b`  out  8 each  latched replacement colour.
- `pe_sum_done`, `pe_bg_done`  in  1 each  PE Qsd and Qbgd.
- `pe_red_sum`, `pe_green_sum`, `pe_blue_sum`  in  8*N each  PE sums; only bits [7+LOG2_N:0] are used.
- `pe_red_out`, `pe_green_out`, `pe_blue_out`  in  8*N each  PE result pixels.
- `out_valid`, `out_ready`  out, in  1 each  output stream handshake.
- `out_r`, `out_g`, `out_b`  out  8 each  output pixel.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a block.
- `err`  out  1  timeout flag; sticky until the next accepted start.

## Operation
States:
- **IDLE**
  - `start` high → copy threshold and bg into `cfg_thr`/`cfg_bg`, clear `err`, set idx=0, go to LOAD.
- **LOAD**
  - `pix_ready`=1.
  - Each transfer (`pix_valid` & `pix_ready`) writes pixel idx into the input buffers, then idx++.
  - The transfer with idx=N-1 → SUM_REQ.
- **SUM_REQ**
  - `pe_start_sum`=1 for exactly one cycle; clear the wait counter; go to SUM_WAIT.
- **SUM_WAIT**
  - `pe_sum_done` high → expected colour := sum[7+LOG2_N:LOG2_N] (truncating mean); `pe_ack`=1 that cycle; go to BG_REQ.
  - No done flag for `TIMEOUT` cycles → set `err`, pulse `pe_ack`, go to DONE.
- **BG_REQ**
  - `pe_start_bg`=1 for one cycle; go to BG_WAIT.
- **BG_WAIT**
  - `pe_bg_done` high → copy the pe_*_out buses into the output buffers; `pe_ack`=1; idx=0; go to DRAIN.
  - Timeout handling is identical to SUM_WAIT.
- **DRAIN**
  - `out_valid`=1; out_r/g/b = output buffer pixel idx.
  - Each transfer (`out_valid` & `out_ready`) → idx++.
  - The transfer with idx=N-1 → DONE.
- **DONE**
  - `done`=1 for one cycle; go to IDLE.

Hold and stability rules:
- `pe_*_exp`, `pe_threshold`, `pe_bg_*` and the `pe_*_in` buses stay constant from SUM_REQ through BG_WAIT.
- `start` outside IDLE is ignored.
- While `out_ready`=0, `out_valid` and the output data hold.
- A pixel offered while `pix_ready`=0 is not consumed.

## Timing
- Reset (synchronous, highest priority, legal mid-block):
  - State → IDLE, any partial block is discarded.
  - All outputs are 0, including the expected colour, config copies, buffers, `err` and idx.
- Command pulses:
  - `pe_start_sum`, `pe_start_bg` and `pe_ack` are registered and never high for more than one cycle.
  - Consecutive pulses are separated by at least one cycle.
- Done-flag qualification: a done flag is acted on only in its matching wait state. `pe_sum_done` seen in BG_WAIT is ignored.
- Latency (zero-wait streams, instant PE): N load cycles, then SUM_REQ, SUM_WAIT, BG_REQ, BG_WAIT, N drain cycles, then DONE. Total = 2N+5 cycles from the start-accept edge to the `done` pulse.
- Wait counter:
  - Counts cycles spent in the wait state, saturating at `TIMEOUT`.
  - A done flag and the timeout in the same cycle → the done flag wins.
- Back-to-back operation: a start seen in IDLE the cycle after DONE is accepted. There are no bubbles beyond that IDLE cycle.

## Test plan
1. N=4, pixels (10,20,30),(14,24,34),(10,20,30),(14,24,34); PE model returns sums 48/88/128 → `pe_*_exp` = 12/22/32, exactly one `pe_start_sum` and one `pe_start_bg` pulse, `done` at cycle 2N+5 = 13.
2. PE model returns outputs (1,2,3),(4,5,6),(7,8,9),(10,11,12); `out_ready` toggled 1,0,0,1,... → four beats in order; data stable while stalled; no beat duplicated or lost.
3. PE model never raises `pe_sum_done` → after `TIMEOUT` cycles, `err`=1, one `pe_ack` pulse, `done` pulse, `pe_start_bg` never asserted; the next start clears `err`.
4. `Reset` asserted after 2 pixels are loaded → the next cycle has `busy`=0 and all outputs 0; a fresh block then loads 4 pixels and completes normally.
5. `start` pulsed during DRAIN, and threshold/bg changed mid-block → ignored; `pe_threshold`/`pe_bg_*` keep the values latched at the first start.
6. Sum truncation: sums 1023/3/0 with N=4 → expected colour 255/0/0.

Source files
------------

// File: rtl/pe_sequencer.sv
// Host-side sequencer for one background-removal PE: buffers a pixel block, requests the PE sum
// and background removal, then streams the replaced pixels out.
module pe_sequencer #(
  parameter int unsigned LOG2_N  = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic [7:0]               threshold,
  input  logic [7:0]               bg_r,
  input  logic [7:0]               bg_g,
  input  logic [7:0]               bg_b,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [7:0]               pix_r,
  input  logic [7:0]               pix_g,
  input  logic [7:0]               pix_b,
  output logic                     pe_start_sum,
  output logic                     pe_start_bg,
  output logic                     pe_ack,
  output logic [(8<<LOG2_N)-1:0]   pe_red_in,
  output logic [(8<<LOG2_N)-1:0]   pe_green_in,
  output logic [(8<<LOG2_N)-1:0]   pe_blue_in,
  output logic [7:0]               pe_red_exp,
  output logic [7:0]               pe_green_exp,
  output logic [7:0]               pe_blue_exp,
  output logic [7:0]               pe_threshold,
  output logic [7:0]               pe_bg_r,
  output logic [7:0]               pe_bg_g,
  output logic [7:0]               pe_bg_b,
  input  logic                     pe_sum_done,
  input  logic                     pe_bg_done,
  input  logic [(8<<LOG2_N)-1:0]   pe_red_sum,
  input  logic [(8<<LOG2_N)-1:0]   pe_green_sum,
  input  logic [(8<<LOG2_N)-1:0]   pe_blue_sum,
  input  logic [(8<<LOG2_N)-1:0]   pe_red_out,
  input  logic [(8<<LOG2_N)-1:0]   pe_green_out,
  input  logic [(8<<LOG2_N)-1:0]   pe_blue_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_r,
  output logic [7:0]               out_g,
  output logic [7:0]               out_b,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned N    = 1 << LOG2_N;
  localparam int unsigned W    = 8 * N;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam int unsigned IdxW = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StLoad, StSumReq, StSumWait, StBgReq, StBgWait, StDrain, StDone
  } state_e;

  state_e          state;
  logic [IdxW-1:0] idx;
  logic [IdxW-1:0] idx_nxt;
  logic [CntW-1:0] wait_cnt;
  logic [W-1:0]    obuf_r, obuf_g, obuf_b;

  assign idx_nxt = idx + 1'b1;

  // Only the mean bits of each sum are consumed.
  logic unused_sum_bits;
  assign unused_sum_bits = ^{pe_red_sum[W-1:8+LOG2_N], pe_red_sum[LOG2_N-1:0],
                             pe_green_sum[W-1:8+LOG2_N], pe_green_sum[LOG2_N-1:0],
                             pe_blue_sum[W-1:8+LOG2_N], pe_blue_sum[LOG2_N-1:0]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= StIdle;
      idx          <= '0;
      wait_cnt     <= '0;
      obuf_r       <= '0;
      obuf_g       <= '0;
      obuf_b       <= '0;
      pix_ready    <= 1'b0;
      pe_start_sum <= 1'b0;
      pe_start_bg  <= 1'b0;
      pe_ack       <= 1'b0;
      pe_red_in    <= '0;
      pe_green_in  <= '0;
      pe_blue_in   <= '0;
      pe_red_exp   <= '0;
      pe_green_exp <= '0;
      pe_blue_exp  <= '0;
      pe_threshold <= '0;
      pe_bg_r      <= '0;
      pe_bg_g      <= '0;
      pe_bg_b      <= '0;
      out_valid    <= 1'b0;
      out_r        <= '0;
      out_g        <= '0;
      out_b        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      pe_start_sum <= 1'b0;
      pe_start_bg  <= 1'b0;
      pe_ack       <= 1'b0;
      done         <= 1'b0;
      case (state)
        StIdle: begin
          if (start) begin
            pe_threshold <= threshold;
            pe_bg_r      <= bg_r;
            pe_bg_g      <= bg_g;
            pe_bg_b      <= bg_b;
            err          <= 1'b0;
            idx          <= '0;
            pix_ready    <= 1'b1;
            busy         <= 1'b1;
            state        <= StLoad;
          end
        end
        StLoad: begin
          if (pix_valid) begin
            pe_red_in[8*idx +: 8]   <= pix_r;
            pe_green_in[8*idx +: 8] <= pix_g;
            pe_blue_in[8*idx +: 8]  <= pix_b;
            idx                     <= idx_nxt;
            if (idx == IdxLast) begin
              pix_ready    <= 1'b0;
              pe_start_sum <= 1'b1;
              state        <= StSumReq;
            end
          end
        end
        StSumReq: begin
          wait_cnt <= '0;
          state    <= StSumWait;
        end
        StSumWait: begin
          if (pe_sum_done) begin
            pe_red_exp   <= pe_red_sum[7+LOG2_N -: 8];
            pe_green_exp <= pe_green_sum[7+LOG2_N -: 8];
            pe_blue_exp  <= pe_blue_sum[7+LOG2_N -: 8];
            pe_ack       <= 1'b1;
            pe_start_bg  <= 1'b1;
            state        <= StBgReq;
          end else if (wait_cnt == CntMax) begin
            err    <= 1'b1;
            pe_ack <= 1'b1;
            done   <= 1'b1;
            state  <= StDone;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        StBgReq: begin
          wait_cnt <= '0;
          state    <= StBgWait;
        end
        StBgWait: begin
          if (pe_bg_done) begin
            obuf_r    <= pe_red_out;
            obuf_g    <= pe_green_out;
            obuf_b    <= pe_blue_out;
            out_r     <= pe_red_out[7:0];
            out_g     <= pe_green_out[7:0];
            out_b     <= pe_blue_out[7:0];
            out_valid <= 1'b1;
            pe_ack    <= 1'b1;
            idx       <= '0;
            state     <= StDrain;
          end else if (wait_cnt == CntMax) begin
            err    <= 1'b1;
            pe_ack <= 1'b1;
            done   <= 1'b1;
            state  <= StDone;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        StDrain: begin
          if (out_ready) begin
            if (idx == IdxLast) begin
              out_valid <= 1'b0;
              out_r     <= '0;
              out_g     <= '0;
              out_b     <= '0;
              done      <= 1'b1;
              state     <= StDone;
            end else begin
              idx   <= idx_nxt;
              out_r <= obuf_r[8*idx_nxt +: 8];
              out_g <= obuf_g[8*idx_nxt +: 8];
              out_b <= obuf_b[8*idx_nxt +: 8];
            end
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
